// File: rtl/imm_gen_pkg.sv
// Shared decode constants for the RV64 immediate generator: widths,
// base opcodes and the immediate format code.
package imm_gen_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

endpackage

// File: rtl/imm_gen_if.sv
// Signal bundle between the decode stage and the immediate generator:
// instruction in, combinational and registered immediates out.
interface imm_gen_if;
    import imm_gen_pkg::*;

    logic [ILEN-1:0] inst;
    logic            en;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      imm_type_q;

    modport master (
        output inst, en,
        input  imm, imm_type, imm_q, imm_type_q
    );

    modport slave (
        input  inst, en,
        output imm, imm_type, imm_q, imm_type_q
    );

endinterface

// File: rtl/imm_gen_comb.sv
// Pure combinational immediate decode; reusable by any stage that needs
// an immediate from a raw instruction word.
module imm_gen_comb
    import imm_gen_pkg::*;
(
    input  logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);

    logic sign;

    assign sign = inst[31];

    // Select the format from the opcode and assemble the immediate fields.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        imm      = {{(XLEN-12){sign}}, inst[31:20]};
        imm_type = IMM_I;
        unique case (inst[6:0])
            OP_STORE: begin
                imm      = {{(XLEN-12){sign}}, inst[31:25], inst[11:7]};
                imm_type = IMM_S;
            end
            OP_BRANCH: begin
                // Halfword offset: the branch unit appends the zero LSB.
                imm      = {{(XLEN-12){sign}}, inst[31], inst[7], inst[30:25], inst[11:8]};
                imm_type = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                // Upper 32 bits stay zero even when inst[31] is set.
                imm      = {32'b0, inst[31:12], 12'b0};
                imm_type = IMM_U;
            end
            OP_JAL: begin
                // Halfword offset: the jump unit appends the zero LSB.
                imm      = {{(XLEN-20){sign}}, inst[31], inst[19:12], inst[20], inst[30:21]};
                imm_type = IMM_J;
            end
            default: begin
                // Loads, OP-IMM, OP-IMM-32, JALR and unknown opcodes: I format.
                imm      = {{(XLEN-12){sign}}, inst[31:20]};
                imm_type = IMM_I;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// RV64 immediate generator: zero-latency decode for the current stage
// plus a load-enabled copy for the decode/execute boundary.
module imm_gen
    import imm_gen_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    imm_gen_if.slave  bus
);

    logic [XLEN-1:0] comb_imm;
    imm_type_e       comb_type;
    logic [XLEN-1:0] imm_r;
    imm_type_e       type_r;

    imm_gen_comb u_comb (
        .inst     (bus.inst),
        .imm      (comb_imm),
        .imm_type (comb_type)
    );

    assign bus.imm        = comb_imm;
    assign bus.imm_type   = comb_type;
    assign bus.imm_q      = imm_r;
    assign bus.imm_type_q = type_r;

    // Pipeline register: synchronous reset wins over the load enable.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (rst) begin
            imm_r  <= '0;
            type_r <= IMM_I;
        end else if (bus.en) begin
            imm_r  <= comb_imm;
            type_r <= comb_type;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: arithmetic reference model checked every
// cycle, plus hand-computed expectations for the directed vectors.
module tb_imm_gen;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   run = 1'b0;

    logic [63:0] exp_q;
    logic [2:0]  exp_tq;

    imm_gen_if bus ();

    imm_gen u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: two's-complement value of a w-bit field, as plain integers.
    function automatic longint signed_field(input longint unsigned v, input int w);
        longint r;
        r = longint'(v);
        if (v >= (64'd1 << (w - 1))) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic logic [2:0] model_type(input logic [31:0] i);
        case (i[6:0])
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] i);
        longint unsigned f;
        case (model_type(i))
            3'd1: begin
                f = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                return signed_field(f, 12);
            end
            3'd2: begin
                f = longint'(i[31]) * 2048 + longint'(i[7]) * 1024
                  + longint'(i[30:25]) * 16 + longint'(i[11:8]);
                return signed_field(f, 12);
            end
            3'd3: return longint'(i[31:12]) * 4096;
            3'd4: begin
                f = longint'(i[31]) * 524288 + longint'(i[19:12]) * 2048
                  + longint'(i[20]) * 1024 + longint'(i[30:21]);
                return signed_field(f, 20);
            end
            default: return signed_field(longint'(i[31:20]), 12);
        endcase
    endfunction

    // Reference register, advanced on the same edge the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            exp_q  = 64'h0;
            exp_tq = 3'd0;
        end else if (bus.en) begin
            exp_q  = model_imm(bus.inst);
            exp_tq = model_type(bus.inst);
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (run) begin
            check("comb_imm",   bus.imm,               model_imm(bus.inst));
            check("comb_type",  {61'b0, bus.imm_type}, {61'b0, model_type(bus.inst)});
            check("reg_imm",    bus.imm_q,             exp_q);
            check("reg_type",   {61'b0, bus.imm_type_q}, {61'b0, exp_tq});
        end
    end

    task automatic apply(input logic [31:0] i, input logic e, input logic r);
        @(posedge clk);
        #2;
        bus.inst = i;
        bus.en   = e;
        rst      = r;
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  typ;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bus.inst = 32'h0;
        bus.en   = 1'b0;
        rst      = 1'b1;
        exp_q    = 'x;
        exp_tq   = 'x;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        check("reset_imm_q",  bus.imm_q, 64'h0);
        check("reset_type_q", {61'b0, bus.imm_type_q}, 64'h0);

        vecs.push_back('{32'h00510093, 64'd5,                 3'd0, "addi"});
        vecs.push_back('{32'h00112423, 64'd8,                 3'd1, "sw"});
        vecs.push_back('{{1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b0000, 1'b1, 7'b1100011},
                         64'hFFFFFFFFFFFFFFF0, 3'd2, "beq_neg"});
        vecs.push_back('{32'hABCDE0B7, 64'h00000000ABCDE000,  3'd3, "lui"});
        vecs.push_back('{32'h123450EF, 64'h0000000000022C91,  3'd4, "jal"});
        vecs.push_back('{32'h80000017, 64'h0000000080000000,  3'd3, "auipc_msb"});
        vecs.push_back('{32'h800000EF, 64'hFFFFFFFFFFF80000,  3'd4, "jal_min"});
        vecs.push_back('{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC,  3'd1, "sw_neg"});
        vecs.push_back('{32'h7FF00067, 64'h00000000000007FF,  3'd0, "jalr_max"});
        vecs.push_back('{32'h80001F9B, 64'hFFFFFFFFFFFFF800,  3'd0, "addiw_min"});
        vecs.push_back('{32'h00AFFF83, 64'd10,                3'd0, "load_junk"});
        vecs.push_back('{32'h7E000FE3, 64'h00000000000007FF,  3'd2, "bne_maxpos"});

        foreach (vecs[k]) begin
            apply(vecs[k].inst, 1'b1, 1'b0);
            check({vecs[k].name, "_imm"},  bus.imm,               vecs[k].imm);
            check({vecs[k].name, "_type"}, {61'b0, bus.imm_type}, {61'b0, vecs[k].typ});
        end

        // Unknown opcode, then load, hold and reset of the register.
        apply(32'hFFF10080, 1'b1, 1'b0);
        check("unk_imm",  bus.imm, 64'hFFFFFFFFFFFFFFFF);
        check("unk_type", {61'b0, bus.imm_type}, 64'h0);
        check("q_prev_imm",  bus.imm_q, 64'h00000000000007FF);
        check("q_prev_type", {61'b0, bus.imm_type_q}, 64'd2);
        apply(32'hABCDE0B7, 1'b0, 1'b0);
        check("q_load_imm",  bus.imm_q, 64'hFFFFFFFFFFFFFFFF);
        check("q_load_type", {61'b0, bus.imm_type_q}, 64'h0);
        apply(32'h123450EF, 1'b1, 1'b1);
        check("q_hold_imm",  bus.imm_q, 64'hFFFFFFFFFFFFFFFF);
        check("q_hold_type", {61'b0, bus.imm_type_q}, 64'h0);
        check("rst_comb_imm", bus.imm, 64'h0000000000022C91);
        apply(32'h123450EF, 1'b1, 1'b0);
        check("q_rst_imm",  bus.imm_q, 64'h0);
        check("q_rst_type", {61'b0, bus.imm_type_q}, 64'h0);
        apply(32'h00510093, 1'b0, 1'b0);
        check("q_after_rst_imm",  bus.imm_q, 64'h0000000000022C91);
        check("q_after_rst_type", {61'b0, bus.imm_type_q}, 64'd4);

        @(posedge clk);
        @(negedge clk);
        #1;
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_gen.md
# imm_gen

RV64 immediate generator for the decode stage. Takes a 32-bit instruction word, selects the immediate format from the opcode, and produces a 64-bit immediate plus a format code. The combinational result feeds the current decode logic with zero latency. A registered copy, with load enable, feeds the decode/execute pipeline boundary.

## Interface
- No parameters. Widths fixed: XLEN = 64, ILEN = 32.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock; only the registered outputs use it.
- `rst`  in  1  synchronous active-high reset.
- `inst`  in  32  instruction word.
- `en`  in  1  load enable for the registered outputs.
- `imm`  out  64  combinational immediate.
- `imm_type`  out  3  combinational format code: 0=I, 1=S, 2=B, 3=U, 4=J.
- `imm_q`  out  64  registered `imm`.
- `imm_type_q`  out  3  registered `imm_type`.

## Operation
Format is selected by `inst[6:0]`:
- I (0000011 load, 0010011 OP-IMM, 0011011 OP-IMM-32, 1100111 JALR):
  - `imm` = sign-extend(`inst[31:20]`).
- S (0100011):
  - `imm` = sign-extend({`inst[31:25]`, `inst[11:7]`}).
- B (1100011):
  - `imm` = sign-extend({`inst[31]`, `inst[7]`, `inst[30:25]`, `inst[11:8]`}), 12 bits.
  - Halfword offset, no appended zero; the branch unit shifts left by 1.
- U (0110111 LUI, 0010111 AUIPC):
  - `imm` = {32'b0, `inst[31:12]`, 12'b0}.
  - Zero-extended: bits 63:32 are always 0, even when `inst[31]`=1.
- J (1101111):
  - `imm` = sign-extend({`inst[31]`, `inst[19:12]`, `inst[20]`, `inst[30:21]`}), 20 bits.
  - Halfword offset, no appended zero.
- Any other opcode: treated as I-type, with `imm_type`=0.
- Sign extension always replicates `inst[31]`.
- `inst` bits outside the selected fields have no effect.

## Timing
- `imm` and `imm_type` are purely combinational from `inst`, with zero cycles of latency. They must be settled within the same delta/time step so a bench sampling 1 ns after changing `inst` sees the new value.
- `imm_q` and `imm_type_q` update on the rising `clk` edge:
  - `rst`=1: both become 0. Reset has priority over `en`.
  - `rst`=0 and `en`=1: capture `imm` and `imm_type`.
  - `rst`=0 and `en`=0: hold.
- Reset value: `imm_q`=64'h0, `imm_type_q`=3'd0.
- Reset asserted mid-stream clears the registered outputs at the next edge. The combinational outputs are unaffected by reset.
- No handshake and no internal state beyond the two registers.

## Structure
- Shared package (e.g. `riscv_pkg`) holds:
  - opcode constants (`OP_LOAD`, `OP_IMM`, `OP_IMM32`, `OP_JALR`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`);
  - the `imm_type_e` enum (I, S, B, U, J);
  - XLEN.
- Optional sub-module `imm_gen_comb`: the pure combinational decode, reused by any other stage that needs immediates. `imm_gen` wraps it with the output register.

## Test plan
- ADDI, `inst`=32'h00510093 -> `imm`=64'd5, `imm_type`=0.
- SW offset 8, `inst`=32'h00112423 -> `imm`=64'd8, `imm_type`=1.
- BEQ with halfword offset -16:
  - `inst`={1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b0000, 1'b1, 7'b1100011};
  - -> `imm`=64'hFFFFFFFFFFFFFFF0, `imm_type`=2.
- LUI, `inst`=32'hABCDE0B7 -> `imm`=64'h00000000ABCDE000 (no sign extension), `imm_type`=3.
- JAL, `inst`=32'h123450EF -> `imm`=64'h0000000000022C91, `imm_type`=4.
- Unknown opcode and register path:
  - `inst`=32'hFFF10080 -> `imm`=64'hFFFFFFFFFFFFFFFF, `imm_type`=0.
  - Edge with `en`=1 -> `imm_q` equals that value.
  - Edge with `en`=0 and a changed `inst` -> `imm_q` holds.
  - Edge with `rst`=1 and `en`=1 -> `imm_q`=0, `imm_type_q`=0.
